// File: rtl/ext_tran_pkg.sv
// Shared definitions for the ext_tran Wishbone master and its lane aligner.
//   - size_e  : host transfer size encoding (byte/half/word/reserved)
//   - state_e : master FSM states
//   - TIMEOUT_CYCLES_DEFAULT : default bus wait limit before abort
//   - is_misaligned() : rejects reserved sizes and unaligned half/word accesses
package ext_tran_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_BUS,
    ST_DONE
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1023;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size_e'(size))
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = (off != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ext_tran_lane_align.sv
// Combinational byte-lane alignment for a 32-bit Wishbone data bus.
//   size_i   : transfer size (size_e encoding)
//   offset_i : byte offset within the word (addr[1:0])
//   wdata_i  : right-justified write data
//   sel_o    : byte enables for the access
//   wdata_o  : write data shifted onto its lanes
//   rdata_i  : raw bus read data
//   rdata_o  : selected lane(s), right-justified and zero-extended
module ext_tran_lane_align
  import ext_tran_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [4:0]  shift;
  logic [31:0] lane;

  always_comb begin
    shift   = {offset_i, 3'b000};
    lane    = rdata_i >> shift;
    sel_o   = '0;
    wdata_o = wdata_i << shift;
    rdata_o = '0;
    case (size_e'(size_i))
      SIZE_BYTE: begin
        sel_o   = 4'b0001 << offset_i;
        rdata_o = {24'h0, lane[7:0]};
      end
      SIZE_HALF: begin
        sel_o   = 4'b0011 << offset_i;
        rdata_o = {16'h0, lane[15:0]};
      end
      SIZE_WORD: begin
        sel_o   = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        wdata_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/ext_tran_wb_master.sv
// Turns one host-posted ext_tran request into a single Wishbone classic cycle.
//   clk_i, reset_i (sync, active-low)
//   ext_tran_*_i : host request (addr, data, size, write, start pulse, clear)
//   ext_tran_data_o/ready_o/err_o : sticky completion status, busy_o = FSM not idle
//   wb_* : Wishbone classic master port; driven only while the cycle is in flight
module ext_tran_wb_master
  import ext_tran_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] ext_tran_addr_i,
  input  logic [31:0]           ext_tran_data_i,
  input  logic [1:0]            ext_tran_size_i,
  input  logic                  ext_tran_write_i,
  input  logic                  ext_tran_start_i,
  input  logic                  ext_tran_clear_i,
  output logic [31:0]           ext_tran_data_o,
  output logic                  ext_tran_ready_o,
  output logic                  ext_tran_err_o,
  output logic                  ext_tran_busy_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [31:0]           wb_dat_i,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;

  logic [3:0]  sel;
  logic [31:0] wdat;
  logic [31:0] rlane;
  logic        in_bus;

  ext_tran_lane_align u_align (
    .size_i   (size_q),
    .offset_i (addr_q[1:0]),
    .wdata_i  (data_q),
    .sel_o    (sel),
    .wdata_o  (wdat),
    .rdata_i  (wb_dat_i),
    .rdata_o  (rlane)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (ext_tran_start_i || ext_tran_clear_i) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          rdata_d = '0;
        end
        if (ext_tran_start_i) begin
          addr_d  = ext_tran_addr_i;
          data_d  = ext_tran_data_i;
          size_d  = ext_tran_size_i;
          we_d    = ext_tran_write_i;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        cnt_d = '0;
        if (is_misaligned(size_q, addr_q[1:0])) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else if (wb_ack_i) begin
          if (!we_q) rdata_d = rlane;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1)) begin
          // cnt_q counts completed BUS cycles, so this is the last permitted one
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lane alignment is combinational off the latched request; gating with
  // in_bus keeps the bus quiet outside the cycle and holds it stable inside.
  assign in_bus           = (state_q == ST_BUS);
  assign wb_cyc_o         = in_bus;
  assign wb_stb_o         = in_bus;
  assign wb_we_o          = in_bus & we_q;
  assign wb_adr_o         = in_bus ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign wb_sel_o         = in_bus ? sel : '0;
  assign wb_dat_o         = in_bus ? wdat : '0;
  assign ext_tran_data_o  = rdata_q;
  assign ext_tran_ready_o = ready_q;
  assign ext_tran_err_o   = err_q;
  assign ext_tran_busy_o  = (state_q != ST_IDLE);

endmodule
